nibble_pair_serializer: RTL and testbench
=========================================

NIBBLE_PAIR_SERIALIZER -- requirements
Module: nibble_pair_serializer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports SHALL be named CLK and RST.
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 Ce  input  1  clock enable; state, capture and transfer SHALL only occur on edges with Ce=1.
REQ-005 Load  input  1  request to capture a digit pair; honoured only in IDLE.
REQ-006 D1in  input  4  high digit (BCD) to send first.
REQ-007 D0in  input  4  low digit (BCD) to send second.
REQ-008 Ready  input  1  downstream accepts Dout on an edge where Valid=1 and Ce=1.
REQ-009 Dout  output  4  current digit being offered.
REQ-010 Valid  output  1  Dout holds a digit awaiting acceptance.
REQ-011 Busy  output  1  a pair is captured and not fully sent.
REQ-012 Done  output  1  one-CLK pulse after the low digit is accepted.
REQ-013 Err  output  1  last Load attempt carried a non-BCD digit.

Function
REQ-014 The FSM SHALL have states IDLE, SEND1, SEND0; encoding is free.
REQ-015 IDLE: Valid=0, Busy=0, Dout=4'h0.
REQ-016 IDLE, Ce=1, Load=1, D1in<=9 and D0in<=9: capture both digits into internal registers, clear Err, go to SEND1.
REQ-017 IDLE, Ce=1, Load=1, either digit >9: capture nothing, set Err=1, remain in IDLE.
REQ-018 Err SHALL hold its value until the next Load accepted in IDLE (valid load clears it, invalid load keeps it 1) or until reset.
REQ-019 SEND1: Valid=1, Busy=1, Dout=captured high digit; on Ce=1 and Ready=1 go to SEND0.
REQ-020 SEND0: Valid=1, Busy=1, Dout=captured low digit; on Ce=1 and Ready=1 go to IDLE and set Done=1 for exactly the next CLK cycle.
REQ-021 Done SHALL be 1 for exactly one CLK cycle regardless of Ce in that cycle.
REQ-022 While Valid=1 and (Ready=0 or Ce=0), Dout, Valid and state SHALL hold unchanged.
REQ-023 Load SHALL be ignored in SEND1 and SEND0, including the edge completing SEND0; captured digits SHALL not change while Busy=1.
REQ-024 Ready SHALL be ignored in IDLE.
REQ-025 Ce=0 SHALL freeze state, captured digits and Err; outputs remain those of the frozen state.
REQ-026 Minimum pair latency: Load edge to Done asserted SHALL be 3 enabled edges when Ready is held 1 (capture, high transfer, low transfer).
REQ-027 Transmit order SHALL be high digit then low digit, so a two-stage 4-bit shift-in receiver clocked once per transfer ends with D1in in its upper stage and D0in in its lower stage.
REQ-028 Outputs Dout, Valid, Busy SHALL be decoded from registered state only (no combinational path from Ready or Load).

Reset
REQ-029 On a CLK edge with RST=1 (independent of Ce): state=IDLE, captured digits=4'h0, Dout=4'h0, Valid=0, Busy=0, Done=0, Err=0.
REQ-030 RST SHALL take priority over Load, Ready and Ce; a reset during SEND1/SEND0 SHALL abort the pair with no Done pulse.

Verification
REQ-031 Reset, Ce=1, Load with D1in=4'h7, D0in=4'h3, Ready=1 -> Dout=7 with Valid for one edge, then Dout=3 for one edge, Done=1 one cycle, Busy=0, Err=0.
REQ-032 Load 4'h2/4'h9, Ready=0 for 5 cycles then 1 -> Dout=2, Valid=1 stable for all 5 stalled cycles, then 2 then 9 transferred, single Done.
REQ-033 Load 4'hA/4'h1 -> Err=1, Busy=0, Valid=0; subsequent Load 4'h4/4'h5 -> Err=0, digits 4 then 5 sent.
REQ-034 During SEND1 with Ready=1, toggle Ce 1,0,0,1 and pulse Load with 4'h8/4'h8 -> state advances only on Ce=1 edges, Load ignored, digits sent are original pair.
REQ-035 Assert RST while in SEND0 -> next cycle all outputs 0, no Done pulse; following Load 4'h1/4'h6 completes normally.
REQ-036 Drive a two-stage 4-bit shift-in register from Dout with Ce=Valid&Ready, send 4'h5/4'h0 -> receiver upper stage=5, lower stage=0.

Source files
------------

// File: rtl/nibble_pair_serializer.sv
// Serializes a captured BCD digit pair, high digit first, over a Valid/Ready handshake.
// Non-BCD load attempts are rejected and flagged on Err until the next load or reset.
module nibble_pair_serializer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Ce,
    input  logic       Load,
    input  logic [3:0] D1in,
    input  logic [3:0] D0in,
    input  logic       Ready,
    output logic [3:0] Dout,
    output logic       Valid,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSend1 = 2'd1,
        StSend0 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_d1;
    logic [3:0] r_d0;
    logic [3:0] w_d1_nxt;
    logic [3:0] w_d0_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic       w_bcd_ok;

    assign w_bcd_ok = (D1in <= 4'd9) && (D0in <= 4'd9);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_d1    <= 4'h0;
            r_d0    <= 4'h0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d1    <= w_d1_nxt;
            r_d0    <= w_d0_nxt;
            r_err   <= w_err_nxt;
            // Done is updated on every edge so the pulse lasts one cycle even with Ce low.
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d1_nxt    = r_d1;
        w_d0_nxt    = r_d0;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;
        if (Ce) begin
            case (r_state)
                StIdle: begin
                    if (Load) begin
                        if (w_bcd_ok) begin
                            w_d1_nxt    = D1in;
                            w_d0_nxt    = D0in;
                            w_err_nxt   = 1'b0;
                            w_state_nxt = StSend1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                StSend1: begin
                    if (Ready) w_state_nxt = StSend0;
                end
                StSend0: begin
                    if (Ready) begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        Dout  = 4'h0;
        Valid = 1'b0;
        Busy  = 1'b0;
        case (r_state)
            StSend1: begin
                Dout  = r_d1;
                Valid = 1'b1;
                Busy  = 1'b1;
            end
            StSend0: begin
                Dout  = r_d0;
                Valid = 1'b1;
                Busy  = 1'b1;
            end
            default: ;
        endcase
    end

    assign Done = r_done;
    assign Err  = r_err;

endmodule

// File: tb/tb_nibble_pair_serializer.sv
// Directed bench for nibble_pair_serializer; outputs are checked packed as
// {Valid, Busy, Done, Err, Dout} one time unit after each rising edge.
module tb_nibble_pair_serializer;

    logic       CLK;
    logic       RST;
    logic       Ce;
    logic       Load;
    logic [3:0] D1in;
    logic [3:0] D0in;
    logic       Ready;
    logic [3:0] Dout;
    logic       Valid;
    logic       Busy;
    logic       Done;
    logic       Err;

    logic [3:0] rx_hi;
    logic [3:0] rx_lo;

    int unsigned n_checks;
    int unsigned n_pass;

    nibble_pair_serializer u_dut (
        .CLK   (CLK),
        .RST   (RST),
        .Ce    (Ce),
        .Load  (Load),
        .D1in  (D1in),
        .D0in  (D0in),
        .Ready (Ready),
        .Dout  (Dout),
        .Valid (Valid),
        .Busy  (Busy),
        .Done  (Done),
        .Err   (Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Two-stage shift-in receiver: new digit enters the lower stage.
    always @(posedge CLK) begin
        if (RST) begin
            rx_hi <= 4'h0;
            rx_lo <= 4'h0;
        end else if (Valid && Ready) begin
            rx_hi <= rx_lo;
            rx_lo <= Dout;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {Valid, Busy, Done, Err, Dout};
    endfunction

    task automatic load(input logic [3:0] hi, input logic [3:0] lo);
        Load = 1'b1;
        D1in = hi;
        D0in = lo;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RST   = 1'b1;
        Ce    = 1'b0;
        Load  = 1'b1;
        D1in  = 4'h7;
        D0in  = 4'h3;
        Ready = 1'b1;
        step();
        check("reset", outs(), 8'h00);
        RST = 1'b0;
        Ce  = 1'b1;

        // Basic pair 7/3 with Ready held high
        load(4'h7, 4'h3);
        step(); check("p73_hi", outs(), 8'hC7);
        Load = 1'b0;
        step(); check("p73_lo", outs(), 8'hC3);
        step(); check("p73_done", outs(), 8'h20);
        step(); check("p73_idle", outs(), 8'h00);

        // Stalled high digit 2/9
        Ready = 1'b0;
        load(4'h2, 4'h9);
        step(); check("p29_hi", outs(), 8'hC2);
        Load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); check("p29_stall", outs(), 8'hC2);
        end
        Ready = 1'b1;
        step(); check("p29_lo", outs(), 8'hC9);
        step(); check("p29_done", outs(), 8'h20);
        step(); check("p29_idle", outs(), 8'h00);

        // Non-BCD load sets Err, valid load clears it
        load(4'hA, 4'h1);
        step(); check("err_set", outs(), 8'h10);
        Load = 1'b0;
        step(); check("err_hold", outs(), 8'h10);
        load(4'h4, 4'h5);
        step(); check("p45_hi", outs(), 8'hC4);
        Load = 1'b0;
        step(); check("p45_lo", outs(), 8'hC5);
        step(); check("p45_done", outs(), 8'h20);
        step(); check("p45_idle", outs(), 8'h00);

        // Ce gating during send; Load 8/8 ignored while busy
        Ready = 1'b0;
        load(4'h6, 4'h1);
        step(); check("p61_hi", outs(), 8'hC6);
        Ready = 1'b1;
        load(4'h8, 4'h8);
        step(); check("ce1_adv", outs(), 8'hC1);
        Ce = 1'b0;
        step(); check("ce0_hold_a", outs(), 8'hC1);
        step(); check("ce0_hold_b", outs(), 8'hC1);
        Ce = 1'b1;
        step(); check("ce1_done", outs(), 8'h20);
        Ce = 1'b0;
        step(); check("done_pulse_ce0", outs(), 8'h00);
        load(4'hF, 4'hF);
        step(); check("ce0_no_err", outs(), 8'h00);
        Load = 1'b0;
        Ce   = 1'b1;

        // Reset during SEND0 aborts with no Done
        load(4'h3, 4'h4);
        step(); check("p34_hi", outs(), 8'hC3);
        Load = 1'b0;
        step(); check("p34_lo", outs(), 8'hC4);
        RST = 1'b1;
        step(); check("rst_abort", outs(), 8'h00);
        RST = 1'b0;
        step(); check("rst_no_done", outs(), 8'h00);
        load(4'h1, 4'h6);
        step(); check("p16_hi", outs(), 8'hC1);
        Load = 1'b0;
        step(); check("p16_lo", outs(), 8'hC6);
        step(); check("p16_done", outs(), 8'h20);

        // Shift-in receiver ends with high digit upper, low digit lower
        load(4'h5, 4'h0);
        step();
        Load = 1'b0;
        step();
        step(); check("p50_done", outs(), 8'h20);
        check("rx_order", {rx_hi, rx_lo}, 8'h50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
